// File: rtl/index_decoder_pkg.sv
// Shared types and helpers for the index decoder: FSM state encoding and
// the hold-counter width calculation.
package index_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    OFFER = 2'd2
  } state_t;

  // Bits needed to hold the value hold_cyc-1 (at least one bit).
  function automatic int unsigned hold_cnt_w(input int unsigned hold_cyc);
    return (hold_cyc > 1) ? $clog2(hold_cyc) : 1;
  endfunction

endpackage

// File: rtl/index_decoder_idx_fifo.sv
// Synchronous FIFO for encoded {val, idx} codes. Full/empty come from an
// extra pointer MSB; pushes while full and pops while empty are ignored.
module idx_fifo #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/index_decoder.sv
// Index decoder: buffers encoded {val, idx} codes, decodes each to a one-hot
// vector, holds it HOLD_CYC cycles and offers it over a valid/ready handshake.
// Optional statistics counters are enabled by defining INDEX_DECODER_STATS_EN.
module index_decoder
  import index_decoder_pkg::*;
#(
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IDX_W-1:0]          in_idx,
  input  logic                      in_val,
  output logic [(1<<IDX_W)-1:0]     out_onehot,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
`ifdef INDEX_DECODER_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [(1<<IDX_W)*CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0]          none_cnt
`endif
);

  localparam int unsigned N   = 1 << IDX_W;
  localparam int unsigned HCW = hold_cnt_w(HOLD_CYC);
  localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYC - 1);

  state_t           state;
  logic [HCW-1:0]   hold_cnt;
  logic [IDX_W:0]   fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load;
  logic [N-1:0]     decoded;

  idx_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (load),
    .din   ({in_val, in_idx}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);

  // Pop a new code from IDLE, or back-to-back when the current one is accepted.
  assign load = !fifo_empty && ((state == IDLE) || ((state == OFFER) && out_ready));

  // One-hot decode of the FIFO head; val=0 decodes to all-zero.
  always_comb begin
    decoded = '0;
    if (fifo_dout[IDX_W]) decoded[fifo_dout[IDX_W-1:0]] = 1'b1;
  end

  // FSM with hold counter and registered one-hot/valid outputs.
  // Loading is hoisted ahead of the state case since IDLE and OFFER share it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else if (load) begin
      out_onehot <= decoded;
      hold_cnt   <= HOLD_INIT;
      if (HOLD_CYC > 1) begin
        state     <= HOLD;
        out_valid <= 1'b0;
      end else begin
        state     <= OFFER;
        out_valid <= 1'b1;
      end
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HCW'(1)) begin
            state     <= OFFER;
            out_valid <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HCW'(1);
          end
        end
        OFFER: begin
          if (out_ready) begin
            state      <= IDLE;
            out_onehot <= '0;
            out_valid  <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          state      <= IDLE;
          out_onehot <= '0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INDEX_DECODER_STATS_EN
  logic handshake;
  assign handshake = (state == OFFER) && out_ready;

  // Saturating per-index and no-request counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      hit_cnt  <= '0;
      none_cnt <= '0;
    end else if (handshake) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (out_onehot[i] && (hit_cnt[i*CNT_W +: CNT_W] != '1))
          hit_cnt[i*CNT_W +: CNT_W] <= hit_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if ((out_onehot == '0) && (none_cnt != '1))
        none_cnt <= none_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_index_decoder.sv
// Self-checking bench for index_decoder: a HOLD_CYC=1 instance driven through
// a vector table and scoreboard, plus a HOLD_CYC=3 instance for hold timing.
module tb_index_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_val, out_ready, in_ready, out_valid, busy;
  logic [1:0] in_idx;
  logic [3:0] out_onehot;
  logic       h_in_valid, h_in_val, h_out_ready, h_in_ready, h_out_valid, h_busy;
  logic [1:0] h_in_idx;
  logic [3:0] h_out_onehot;
`ifdef INDEX_DECODER_STATS_EN
  logic        stats_clr;
  logic [31:0] hit_cnt, h_hit_cnt;
  logic [7:0]  none_cnt, h_none_cnt;
`endif

  index_decoder #(.IDX_W(2), .DEPTH(4), .HOLD_CYC(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_val(in_val), .out_onehot(out_onehot),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef INDEX_DECODER_STATS_EN
    , .stats_clr(stats_clr), .hit_cnt(hit_cnt), .none_cnt(none_cnt)
`endif
  );

  index_decoder #(.IDX_W(2), .DEPTH(4), .HOLD_CYC(3), .CNT_W(8)) dut_h3 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_idx(h_in_idx), .in_val(h_in_val), .out_onehot(h_out_onehot),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .busy(h_busy)
`ifdef INDEX_DECODER_STATS_EN
    , .stats_clr(stats_clr), .hit_cnt(h_hit_cnt), .none_cnt(h_none_cnt)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [1:0] idx;
    logic       rdy;
    logic [3:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [3:0]  exp_q [$];
  logic [3:0]  sb_e;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_out    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic v, input logic [1:0] i, input logic [3:0] e);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_val   = v;
    in_idx   = i;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  // Scoreboard: compare each completed output handshake against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'(out_onehot), 32'hFFFF_FFFF);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_onehot", 32'(out_onehot), 32'(sb_e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned vcnt;

    vecs[0] = '{1'b1, 2'd3, 1'b1, 4'b1000};
    vecs[1] = '{1'b1, 2'd1, 1'b0, 4'b0010};
    vecs[2] = '{1'b0, 2'd2, 1'b0, 4'b0000};
    vecs[3] = '{1'b1, 2'd0, 1'b1, 4'b0001};
    vecs[4] = '{1'b1, 2'd2, 1'b0, 4'b0100};
    vecs[5] = '{1'b0, 2'd0, 1'b1, 4'b0000};
    vecs[6] = '{1'b1, 2'd1, 1'b1, 4'b0010};
    vecs[7] = '{1'b1, 2'd3, 1'b0, 4'b1000};

    rst = 1'b1; in_valid = 1'b0; in_val = 1'b0; in_idx = '0; out_ready = 1'b0;
    h_in_valid = 1'b0; h_in_val = 1'b0; h_in_idx = '0; h_out_ready = 1'b0;
`ifdef INDEX_DECODER_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_h3_in_ready", 32'(h_in_ready), 32'd1);
    step();

    // HOLD_CYC=1 latency: idx=2 -> 0100 with out_valid after one edge
    out_ready = 1'b1;
    send(1'b1, 2'd2, 4'b0100);
    @(negedge clk);
    check("lat1_pre_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat1_onehot", 32'(out_onehot), 32'h4);
    check("lat1_valid", 32'(out_valid), 32'd1);
    check("lat1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat1_idle_valid", 32'(out_valid), 32'd0);
    check("lat1_idle_onehot", 32'(out_onehot), 32'd0);
    step();

    // HOLD_CYC=3: one-hot held 2 cycles without valid, then valid until ready
    h_in_valid = 1'b1; h_in_val = 1'b1; h_in_idx = 2'd1;
    @(negedge clk);
    check("h3_in_ready", 32'(h_in_ready), 32'd1);
    step();
    h_in_valid = 1'b0;
    @(negedge clk);
    check("h3_t0_valid", 32'(h_out_valid), 32'd0);
    @(negedge clk);
    check("h3_t1_onehot", 32'(h_out_onehot), 32'h2);
    check("h3_t1_valid", 32'(h_out_valid), 32'd0);
    @(negedge clk);
    check("h3_t2_onehot", 32'(h_out_onehot), 32'h2);
    check("h3_t2_valid", 32'(h_out_valid), 32'd0);
    @(negedge clk);
    check("h3_t3_valid", 32'(h_out_valid), 32'd1);
    check("h3_t3_onehot", 32'(h_out_onehot), 32'h2);
    @(negedge clk);
    check("h3_wait_valid", 32'(h_out_valid), 32'd1);
    step();
    h_out_ready = 1'b1;
    @(negedge clk);
    check("h3_offer_valid", 32'(h_out_valid), 32'd1);
    step();
    h_out_ready = 1'b0;
    @(negedge clk);
    check("h3_done_valid", 32'(h_out_valid), 32'd0);
    check("h3_done_onehot", 32'(h_out_onehot), 32'd0);
    check("h3_done_busy", 32'(h_busy), 32'd0);
    step();

    // Full buffering: 5 codes with out_ready=0, 6th held until space frees
    out_ready = 1'b0;
    base = n_out;
    send(1'b1, 2'd0, 4'b0001);
    send(1'b1, 2'd1, 4'b0010);
    send(1'b1, 2'd2, 4'b0100);
    send(1'b1, 2'd3, 4'b1000);
    send(1'b0, 2'd0, 4'b0000);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_onehot", 32'(out_onehot), 32'h1);
    check("full_out_valid", 32'(out_valid), 32'd1);
    step();
    in_valid = 1'b1; in_val = 1'b1; in_idx = 2'd3;
    repeat (3) begin
      @(negedge clk);
      check("full_held", 32'(in_ready), 32'd0);
    end
    step();
    out_ready = 1'b1;
    send(1'b1, 2'd3, 4'b1000);
    wait_drain();
    check("full_emitted_count", n_out - base, 32'd6);

    // val=0 then idx=3 back-to-back -> 0000 then 1000 on consecutive cycles
    send(1'b0, 2'd1, 4'b0000);
    send(1'b1, 2'd3, 4'b1000);
    @(negedge clk);
    check("b2b_first_onehot", 32'(out_onehot), 32'h0);
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("b2b_second_onehot", 32'(out_onehot), 32'h8);
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    step();
    wait_drain();
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    step();

    // Table-driven vectors with varying downstream readiness
    for (int i = 0; i < 8; i++) begin
      out_ready = vecs[i].rdy;
      send(vecs[i].v, vecs[i].idx, vecs[i].exp);
    end
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-OFFER with 3 codes queued behind the offered one
    out_ready = 1'b0;
    send(1'b1, 2'd1, 4'b0010);
    send(1'b1, 2'd2, 4'b0100);
    send(1'b1, 2'd3, 4'b1000);
    send(1'b1, 2'd0, 4'b0001);
    @(negedge clk);
    check("mid_offer_valid", 32'(out_valid), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_onehot", 32'(out_onehot), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    out_ready = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("midrst_no_emit", vcnt, 32'd0);
    step();

`ifdef INDEX_DECODER_STATS_EN
    // Statistics: saturation at 255 and clear
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    repeat (300) send(1'b1, 2'd0, 4'b0001);
    wait_drain();
    @(negedge clk);
    check("stats_hit0_sat", 32'(hit_cnt[7:0]), 32'd255);
    check("stats_hit1_zero", 32'(hit_cnt[15:8]), 32'd0);
    check("stats_none_zero", 32'(none_cnt), 32'd0);
    step();
    send(1'b0, 2'd0, 4'b0000);
    wait_drain();
    @(negedge clk);
    check("stats_none_one", 32'(none_cnt), 32'd1);
    step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clr_hit", hit_cnt, 32'd0);
    check("stats_clr_none", 32'(none_cnt), 32'd0);
    step();
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
